// File: rtl/inst_fetch_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_queue_if
// Description : Bundle of the instruction-fetch queue signals: the
//               instruction-memory request channel, the instruction output
//               stream towards the decoder and the redirect input.
//               master : the fetch queue itself
//               slave  : the environment (memory, consumer, branch unit)
// Signals     : mem_req/mem_addr        - word read request (addr = PC[31:2])
//               mem_ack/mem_data        - same-cycle accept + data return
//               inst/inst_pc/inst_valid - queue head (first-word-fall-through)
//               inst_ready              - consumer takes the head
//               redirect/redirect_pc    - flush and restart fetch
// Revision    : 1.0 - initial release
// ============================================================================
interface inst_fetch_queue_if;
  logic        mem_req;
  logic [29:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  modport master (
    output mem_req, mem_addr, inst, inst_pc, inst_valid,
    input  mem_ack, mem_data, inst_ready, redirect, redirect_pc
  );

  modport slave (
    input  mem_req, mem_addr, inst, inst_pc, inst_valid,
    output mem_ack, mem_data, inst_ready, redirect, redirect_pc
  );
endinterface
`default_nettype wire

// File: rtl/inst_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_queue
// Description : Instruction prefetch queue. Issues one word read at a time to
//               instruction memory, stores {instruction, byte PC} in a
//               DEPTH-entry first-word-fall-through FIFO and supports
//               redirects that flush the queue and discard in-flight data.
// Parameters  : DEPTH - queue entries, power of two in 2..16 (default 4)
// Ports       : clk_i          - rising-edge clock
//               rst_ni         - asynchronous active-low reset
//               bus            - inst_fetch_queue_if.master (memory channel,
//                                instruction stream, redirect)
//               fetch_except_o - sticky misaligned-redirect flag (only with
//                                FETCH_ALIGN_CHECK_EN)
// Options     : FETCH_ALIGN_CHECK_EN - when defined, a redirect to a PC with
//               bits [1:0] != 0 raises fetch_except_o and halts fetching
//               until reset. When undefined, such a PC is truncated to a
//               word boundary.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_queue #(
  parameter int DEPTH = 4
) (
  input  wire                clk_i,
  input  wire                rst_ni,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic               fetch_except_o,
`endif
  inst_fetch_queue_if.master bus
);

  localparam int c_cnt_w = $clog2(DEPTH + 1);
  localparam int c_ptr_w = $clog2(DEPTH);
  localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

  // IDLE: nothing outstanding; REQ: live request; DROP: request whose data
  // belongs to a flushed instruction stream and must be thrown away.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [29:0]        addr_q, addr_d;
  logic [c_cnt_w-1:0] count_q, count_d;
  logic [c_cnt_w-1:0] count_after_pop;
  logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]        inst_q, inst_d;
  logic [31:0]        inst_pc_q, inst_pc_d;
  logic [63:0]        entries_q [DEPTH];

  logic               push;
  logic               pop;
  logic               issue_ok;
  logic [31:0]        redirect_target;

  // --------------------------------------------------------------------------
  // Optional misaligned-redirect trap
  // --------------------------------------------------------------------------
`ifdef FETCH_ALIGN_CHECK_EN
  logic except_q, except_d;

  assign except_d = except_q | (bus.redirect & (bus.redirect_pc[1:0] != 2'b00));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      except_q <= 1'b0;
    end else begin
      except_q <= except_d;
    end
  end

  assign fetch_except_o = except_q;
  // Once trapped, no new request may start; an in-flight one still drains.
  assign issue_ok       = ~except_q;
`else
  logic unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];
  assign issue_ok             = 1'b1;
`endif

  // Fetch always proceeds on word boundaries.
  assign redirect_target = {bus.redirect_pc[31:2], 2'b00};

  // --------------------------------------------------------------------------
  // Request FSM: next state, fetch PC and request address
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    push       = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A late mem_ack (e.g. one that belonged to a request abandoned by
        // reset) is deliberately ignored here.
        if (!bus.redirect && (count_q < c_depth) && issue_ok) begin
          state_d = REQ;
          addr_d  = fetch_pc_q[31:2];
        end
      end
      REQ: begin
        if (bus.mem_ack) begin
          state_d = IDLE;
          // Data returned in the redirect cycle belongs to the old stream.
          if (!bus.redirect) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
          end
        end else if (bus.redirect) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (bus.mem_ack) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A redirect always wins over the increment; in DROP it only retargets
    // the PC while the stale request keeps its address on the bus.
    if (bus.redirect) begin
      fetch_pc_d = redirect_target;
    end
  end

  // --------------------------------------------------------------------------
  // Queue bookkeeping
  // --------------------------------------------------------------------------
  // Space is checked before issue, so a push can never find the queue full.
  assign pop             = (count_q != '0) & bus.inst_ready & ~bus.redirect;
  assign count_after_pop = count_q - c_cnt_w'(pop);

  always_comb begin
    count_d   = count_after_pop + c_cnt_w'(push);
    wr_ptr_d  = wr_ptr_q + c_ptr_w'(push);
    rd_ptr_d  = rd_ptr_q + c_ptr_w'(pop);
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;

    if (bus.redirect) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end

    // The head is kept in its own register so it can hold the last value
    // while empty. The new head is either an entry already stored or, when
    // the queue drains to nothing in this cycle, the word being pushed.
    if (count_d != '0) begin
      if (count_after_pop == '0) begin
        inst_d    = bus.mem_data;
        inst_pc_d = fetch_pc_q;
      end else begin
        inst_d    = entries_q[rd_ptr_d][63:32];
        inst_pc_d = entries_q[rd_ptr_d][31:0];
      end
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      fetch_pc_q <= '0;
      addr_q     <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      inst_q     <= '0;
      inst_pc_q  <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      inst_q     <= inst_d;
      inst_pc_q  <= inst_pc_d;
    end
  end

  // Storage needs no reset: an entry is only read after it was written.
  always_ff @(posedge clk_i) begin
    if (push) begin
      entries_q[wr_ptr_q] <= {bus.mem_data, fetch_pc_q};
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // The request is a function of state only, so it stays stable until acked.
  assign bus.mem_req    = (state_q != IDLE);
  assign bus.mem_addr   = addr_q;
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;
  assign bus.inst_valid = (count_q != '0);

endmodule
`default_nettype wire
